// File: rtl/req_grant_sequencer_if.sv
// Request/grant bundle between request sources, the sequencer and its consumer.
// Carries merge_cnt_o only when REQ_MERGE_CNT_EN is defined.
interface req_grant_sequencer_if #(
  parameter int unsigned WIDTH = 8
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  logic [WIDTH-1:0] req_i;
  logic [WIDTH-1:0] pend_o;
  logic             gnt_valid_o;
  logic [WIDTH-1:0] gnt_onehot_o;
  logic [IDX_W-1:0] gnt_idx_o;
  logic             gnt_ready_i;
`ifdef REQ_MERGE_CNT_EN
  logic [7:0]       merge_cnt_o;
`endif

  modport master (
    input  req_i,
    input  gnt_ready_i,
    output pend_o,
    output gnt_valid_o,
    output gnt_onehot_o,
`ifdef REQ_MERGE_CNT_EN
    output merge_cnt_o,
`endif
    output gnt_idx_o
  );

  modport slave (
    output req_i,
    output gnt_ready_i,
    input  pend_o,
    input  gnt_valid_o,
    input  gnt_onehot_o,
`ifdef REQ_MERGE_CNT_EN
    input  merge_cnt_o,
`endif
    input  gnt_idx_o
  );
endinterface

// File: rtl/req_grant_sequencer.sv
// Sticky request collector that grants the lowest pending bit over valid/ready.
// Optional saturating merge counter enabled by REQ_MERGE_CNT_EN.
module req_grant_sequencer #(
  parameter int unsigned WIDTH = 8
) (
  input logic                   clk,
  input logic                   rst,
  req_grant_sequencer_if.master bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);

  typedef enum logic {StIdle, StOffer} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] onehot_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;

  logic             accept;
  logic [WIDTH-1:0] retire, rem, cand, sel_onehot;
  logic [IDX_W-1:0] sel_idx;

  assign accept = valid_q & bus.gnt_ready_i;
  assign retire = accept ? onehot_q : '0;
  // Set wins over retire so a same-cycle re-request stays pending.
  assign pend_d = (pend_q & ~retire) | bus.req_i;
  assign rem    = pend_q & ~onehot_q;
  assign cand   = (state_q == StIdle) ? pend_q : rem;
  assign sel_onehot = cand & (-cand);

  always_comb begin
    sel_idx = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (cand[i]) sel_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      pend_q   <= '0;
      onehot_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        StIdle: begin
          if (|pend_q) begin
            onehot_q <= sel_onehot;
            idx_q    <= sel_idx;
            valid_q  <= 1'b1;
            state_q  <= StOffer;
          end
        end
        StOffer: begin
          if (accept) begin
            if (|rem) begin
              onehot_q <= sel_onehot;
              idx_q    <= sel_idx;
            end else begin
              onehot_q <= '0;
              idx_q    <= '0;
              valid_q  <= 1'b0;
              state_q  <= StIdle;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.pend_o       = pend_q;
  assign bus.gnt_valid_o  = valid_q;
  assign bus.gnt_onehot_o = onehot_q;
  assign bus.gnt_idx_o    = idx_q;

`ifdef REQ_MERGE_CNT_EN
  logic [7:0]       merge_cnt_q;
  logic [WIDTH-1:0] absorb;
  logic [5:0]       merge_inc;
  logic [8:0]       merge_sum;

  assign absorb = bus.req_i & pend_q & ~retire;

  always_comb begin
    merge_inc = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      merge_inc = merge_inc + 6'(absorb[i]);
    end
  end

  assign merge_sum = {1'b0, merge_cnt_q} + {3'b000, merge_inc};

  always_ff @(posedge clk) begin
    if (rst) begin
      merge_cnt_q <= '0;
    end else begin
      merge_cnt_q <= merge_sum[8] ? 8'hff : merge_sum[7:0];
    end
  end

  assign bus.merge_cnt_o = merge_cnt_q;
`endif
endmodule

// File: tb/tb_req_grant_sequencer.sv
// Bench for req_grant_sequencer: directed vector table, hand sequences, and random
// stimulus checked against a behavioural model.
module tb_req_grant_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;

  req_grant_sequencer_if #(.WIDTH(8)) bus ();

  req_grant_sequencer #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic       rdy;
    logic [7:0] pend;
    logic       valid;
    logic [7:0] onehot;
    logic [2:0] idx;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Behavioural model: pending set, index of the offered grant (-1 = none).
  logic [7:0] m_pend = '0;
  int         m_g    = -1;
  int         m_mc   = 0;

  function automatic int lowest(logic [7:0] v);
    for (int i = 0; i < 8; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step(logic r, logic [7:0] req, logic rdy);
    logic [7:0] nxt;
    logic       acc;
    if (r) begin
      m_pend = '0;
      m_g    = -1;
      m_mc   = 0;
    end else begin
      acc = (m_g >= 0) && rdy;
      for (int i = 0; i < 8; i++) begin
        if (req[i] && m_pend[i] && !(acc && i == m_g)) m_mc = m_mc + 1;
      end
      if (m_mc > 255) m_mc = 255;
      nxt = m_pend;
      if (acc) nxt[m_g] = 1'b0;
      nxt = nxt | req;
      if (m_g < 0) begin
        m_g = lowest(m_pend);
      end else if (acc) begin
        logic [7:0] rest;
        rest = m_pend;
        rest[m_g] = 1'b0;
        m_g = lowest(rest);
      end
      m_pend = nxt;
    end
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(logic r, logic [7:0] req, logic rdy);
    rst             = r;
    bus.req_i       = req;
    bus.gnt_ready_i = rdy;
    @(posedge clk);
    model_step(r, req, rdy);
    #1;
  endtask

  task automatic check_model(string tag);
    check({tag, ".pend"},   32'(bus.pend_o),       32'(m_pend));
    check({tag, ".valid"},  32'(bus.gnt_valid_o),  32'(m_g >= 0));
    check({tag, ".onehot"}, 32'(bus.gnt_onehot_o), (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
    check({tag, ".idx"},    32'(bus.gnt_idx_o),    (m_g >= 0) ? 32'(m_g) : 32'd0);
`ifdef REQ_MERGE_CNT_EN
    check({tag, ".merge"},  32'(bus.merge_cnt_o),  32'(m_mc));
`endif
  endtask

  task automatic add(logic r, logic [7:0] req, logic rdy, logic [7:0] pend, logic v,
                     logic [7:0] oh, logic [2:0] idx);
    vec_t e;
    e = '{rst: r, req: req, rdy: rdy, pend: pend, valid: v, onehot: oh, idx: idx};
    vecs.push_back(e);
  endtask

  initial begin
    bus.req_i       = '0;
    bus.gnt_ready_i = 1'b0;

    // Reset, req ignored during reset, then 10 idle cycles.
    add(1, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    add(1, 8'hff, 1, 8'h00, 0, 8'h00, 0);
    for (int i = 0; i < 10; i++) add(0, 8'h00, 0, 8'h00, 0, 8'h00, 0);
    // Single request.
    add(0, 8'h10, 1, 8'h10, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'h10, 1, 8'h10, 4);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
    // Priority drain, ready held high.
    add(0, 8'ha6, 1, 8'ha6, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'ha6, 1, 8'h02, 1);
    add(0, 8'h00, 1, 8'ha4, 1, 8'h04, 2);
    add(0, 8'h00, 1, 8'ha0, 1, 8'h20, 5);
    add(0, 8'h00, 1, 8'h80, 1, 8'h80, 7);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
    // Backpressure, late higher-priority request must not pre-empt.
    add(0, 8'h80, 0, 8'h80, 0, 8'h00, 0);
    add(0, 8'h00, 0, 8'h80, 1, 8'h80, 7);
    add(0, 8'h00, 0, 8'h80, 1, 8'h80, 7);
    add(0, 8'h01, 0, 8'h81, 1, 8'h80, 7);
    add(0, 8'h00, 0, 8'h81, 1, 8'h80, 7);
    add(0, 8'h00, 1, 8'h01, 1, 8'h01, 0);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);
    // Same-cycle retire and re-request of bit 2.
    add(0, 8'h04, 0, 8'h04, 0, 8'h00, 0);
    add(0, 8'h00, 0, 8'h04, 1, 8'h04, 2);
    add(0, 8'h04, 1, 8'h04, 0, 8'h00, 0);
    add(0, 8'h00, 1, 8'h04, 1, 8'h04, 2);
    add(0, 8'h00, 1, 8'h00, 0, 8'h00, 0);

    foreach (vecs[k]) begin
      drive(vecs[k].rst, vecs[k].req, vecs[k].rdy);
      check($sformatf("vec%0d.pend", k),   32'(bus.pend_o),       32'(vecs[k].pend));
      check($sformatf("vec%0d.valid", k),  32'(bus.gnt_valid_o),  32'(vecs[k].valid));
      check($sformatf("vec%0d.onehot", k), 32'(bus.gnt_onehot_o), 32'(vecs[k].onehot));
      check($sformatf("vec%0d.idx", k),    32'(bus.gnt_idx_o),    32'(vecs[k].idx));
    end

    // Reset mid-offer, then merge of a repeated request.
    drive(0, 8'h0c, 0);
    drive(0, 8'h00, 0);
    check("midoff.onehot", 32'(bus.gnt_onehot_o), 32'h04);
    drive(1, 8'h00, 0);
    check("midrst.pend",   32'(bus.pend_o),       32'h00);
    check("midrst.valid",  32'(bus.gnt_valid_o),  32'h0);
    check("midrst.onehot", 32'(bus.gnt_onehot_o), 32'h00);
    check("midrst.idx",    32'(bus.gnt_idx_o),    32'h0);
`ifdef REQ_MERGE_CNT_EN
    check("midrst.merge",  32'(bus.merge_cnt_o),  32'h0);
`endif
    for (int i = 0; i < 3; i++) drive(0, 8'h01, 0);
    check("merge.pend",  32'(bus.pend_o),      32'h01);
    check("merge.valid", 32'(bus.gnt_valid_o), 32'h1);
`ifdef REQ_MERGE_CNT_EN
    check("merge.cnt",   32'(bus.merge_cnt_o), 32'd2);
`endif

    // Long all-ones burst under backpressure drives the merge counter to saturation.
    for (int i = 0; i < 40; i++) begin
      drive(0, 8'hff, 0);
      check_model("sat");
    end
`ifdef REQ_MERGE_CNT_EN
    check("sat.cnt", 32'(bus.merge_cnt_o), 32'd255);
`endif

    // Randomised traffic against the model.
    drive(1, 8'h00, 0);
    check_model("rnd_rst");
    for (int i = 0; i < 600; i++) begin
      logic       r;
      logic [7:0] rq;
      logic       rd;
      r  = ($urandom_range(0, 79) == 0);
      rq = 8'($urandom) & 8'($urandom) & 8'($urandom);
      rd = ($urandom_range(0, 3) != 0);
      drive(r, rq, rd);
      check_model("rnd");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
